// File: rtl/poly_tone_if.sv
// Note-command channel from the sequencer/ROM layer into poly_tone_gen.
// Signal suffixes are from the generator's point of view.
interface poly_tone_if #(
  parameter int VW    = 2,
  parameter int BW    = 24,
  parameter int AMP_W = 4,
  parameter int LEN_W = 8
) ();
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [VW-1:0]    cmd_voice_i;
  logic             cmd_stop_i;
  logic [BW-1:0]    cmd_period_i;
  logic [AMP_W-1:0] cmd_amp_i;
  logic [LEN_W-1:0] cmd_len_i;

  modport master (
    output cmd_valid_i, cmd_voice_i, cmd_stop_i, cmd_period_i, cmd_amp_i, cmd_len_i,
    input  cmd_ready_o
  );

  modport slave (
    input  cmd_valid_i, cmd_voice_i, cmd_stop_i, cmd_period_i, cmd_amp_i, cmd_len_i,
    output cmd_ready_o
  );
endinterface

// File: rtl/poly_tone_gen.sv
// Polyphonic square-wave tone generator with per-voice linear ASR envelopes,
// a registered mixer and a 1-bit PWM output stage.
//
// state   | meaning
// IDLE    | voice silent, E=0, phase/sq held at 0
// ATTACK  | E rises by one per strobe until it reaches the peak A
// SUSTAIN | E held at A for L+1 strobes
// RELEASE | E falls by one per strobe, back to IDLE at 0
module poly_tone_gen #(
  parameter int  NUM_VOICES = 4,
  parameter int  BW         = 24,
  parameter int  AMP_W      = 4,
  parameter int  LEN_W      = 8,
  localparam int VW         = $clog2(NUM_VOICES),
  localparam int SW         = AMP_W + VW
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  strb_i,
  poly_tone_if.slave            cmd,
  output logic [NUM_VOICES-1:0] voice_busy_o,
  output logic [SW-1:0]         level_o,
  output logic                  pwm_o
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ATTACK  = 2'd1;
  localparam logic [1:0] ST_SUSTAIN = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic             accept;
  logic             hold_full_q;
  logic [VW-1:0]    hold_voice_q;
  logic             hold_stop_q;
  logic [BW-1:0]    hold_period_q;
  logic [AMP_W-1:0] hold_amp_q;
  logic [LEN_W-1:0] hold_len_q;

  logic [AMP_W-1:0] mix_term [NUM_VOICES];
  logic [SW-1:0]    level_d;
  logic [SW-1:0]    level_q;
  logic [SW-1:0]    pc_q;
  logic             pwm_q;

  assign cmd.cmd_ready_o = ~hold_full_q;
  assign accept          = cmd.cmd_valid_i & ~hold_full_q & ~rst_i;

  // One-entry command buffer: captured on accept, applied and freed on the next edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) hold_full_q <= 1'b0;
    else       hold_full_q <= accept;
    if (accept) begin
      hold_voice_q  <= cmd.cmd_voice_i;
      hold_stop_q   <= cmd.cmd_stop_i;
      hold_period_q <= cmd.cmd_period_i;
      hold_amp_q    <= cmd.cmd_amp_i;
      hold_len_q    <= cmd.cmd_len_i;
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    logic [1:0]       st_q, st_d;
    logic [AMP_W-1:0] e_q, e_d, a_q, a_d;
    logic [LEN_W-1:0] l_q, l_d;
    logic [BW-1:0]    p_q, p_d, ph_q, ph_d;
    logic             sq_q, sq_d;
    logic             apply;
    logic             start;

    // Voice indices that do not exist never match, so such commands are dropped.
    assign apply = hold_full_q && (hold_voice_q == VW'(v));
    // A zero period or zero amplitude cannot make a note, so it acts as a stop.
    assign start = apply && !hold_stop_q && (hold_period_q != '0) && (hold_amp_q != '0);

    // Tone phase plus envelope step; an applied command masks a coincident strobe.
    always_comb begin
      st_d = st_q;
      e_d  = e_q;
      a_d  = a_q;
      l_d  = l_q;
      p_d  = p_q;
      ph_d = ph_q;
      sq_d = sq_q;

      if (start) begin
        ph_d = '0;
        sq_d = 1'b0;
      end else if (st_q != ST_IDLE) begin
        if (ph_q == p_q - BW'(1)) begin
          ph_d = '0;
          sq_d = ~sq_q;
        end else begin
          ph_d = ph_q + BW'(1);
        end
      end

      if (start) begin
        st_d = ST_ATTACK;
        e_d  = '0;
        a_d  = hold_amp_q;
        l_d  = hold_len_q;
        p_d  = hold_period_q;
      end else if (apply) begin
        if (st_q == ST_ATTACK || st_q == ST_SUSTAIN) st_d = ST_RELEASE;
      end else if (strb_i) begin
        case (st_q)
          ST_ATTACK: begin
            e_d = e_q + AMP_W'(1);
            if (e_d == a_q) st_d = ST_SUSTAIN;
          end
          ST_SUSTAIN: begin
            if (l_q == '0) st_d = ST_RELEASE;
            else           l_d  = l_q - LEN_W'(1);
          end
          ST_RELEASE: begin
            // A stop before the first attack strobe releases from E=0; never wrap.
            if (e_q <= AMP_W'(1)) begin
              e_d  = '0;
              st_d = ST_IDLE;
            end else begin
              e_d = e_q - AMP_W'(1);
            end
          end
          default: e_d = '0;
        endcase
      end

      if (st_d == ST_IDLE) begin
        ph_d = '0;
        sq_d = 1'b0;
      end
    end

    // Voice state registers.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        st_q <= ST_IDLE;
        e_q  <= '0;
        a_q  <= '0;
        l_q  <= '0;
        p_q  <= '0;
        ph_q <= '0;
        sq_q <= 1'b0;
      end else begin
        st_q <= st_d;
        e_q  <= e_d;
        a_q  <= a_d;
        l_q  <= l_d;
        p_q  <= p_d;
        ph_q <= ph_d;
        sq_q <= sq_d;
      end
    end

    assign voice_busy_o[v] = (st_q != ST_IDLE);
    assign mix_term[v]     = sq_q ? e_q : '0;
  end

  // Sum of every voice whose square is currently high; sized so it cannot overflow.
  always_comb begin
    level_d = '0;
    for (int v = 0; v < NUM_VOICES; v++) level_d = level_d + SW'(mix_term[v]);
  end

  // Registered mix level, free-running PWM carrier and comparator.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= '0;
      pc_q    <= '0;
      pwm_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      pc_q    <= pc_q + SW'(1);
      pwm_q   <= (level_q > pc_q);
    end
  end

  assign level_o = level_q;
  assign pwm_o   = pwm_q;
endmodule

// File: tb/tb_poly_tone_gen.sv
// Self-checking bench for poly_tone_gen: directed command table, hand-written
// corner sequences and a randomized run, all compared each cycle against a
// behavioural voice/mixer/PWM model.
module tb_poly_tone_gen;
  localparam int NV    = 4;
  localparam int VW    = 2;
  localparam int BW    = 24;
  localparam int AMP_W = 4;
  localparam int LEN_W = 8;
  localparam int SW    = 6;

  localparam int M_IDLE = 0, M_ATK = 1, M_SUS = 2, M_REL = 3;

  logic          clk;
  logic          rst;
  logic          strb;
  logic [NV-1:0] busy;
  logic [SW-1:0] level;
  logic          pwm;

  poly_tone_if #(.VW(VW), .BW(BW), .AMP_W(AMP_W), .LEN_W(LEN_W)) cmd_if ();

  poly_tone_gen #(.NUM_VOICES(NV), .BW(BW), .AMP_W(AMP_W), .LEN_W(LEN_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .strb_i       (strb),
    .cmd          (cmd_if),
    .voice_busy_o (busy),
    .level_o      (level),
    .pwm_o        (pwm)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int m_st[NV], m_e[NV], m_a[NV], m_l[NV], m_p[NV], m_ph[NV], m_sq[NV];
  int m_level, m_pc, m_pwm;
  bit m_hf;
  int m_hv, m_hs, m_hp, m_ha, m_hl;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int v = 0; v < NV; v++) begin
      m_st[v] = M_IDLE; m_e[v] = 0; m_a[v] = 0; m_l[v] = 0;
      m_p[v] = 0; m_ph[v] = 0; m_sq[v] = 0;
    end
    m_level = 0; m_pc = 0; m_pwm = 0; m_hf = 0;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  function automatic void model_step();
    int sum;
    bit ap, st_cmd;
    if (rst) begin
      model_reset();
      return;
    end
    sum = 0;
    for (int v = 0; v < NV; v++) if (m_sq[v] != 0) sum += m_e[v];
    m_pwm   = (m_level > m_pc) ? 1 : 0;
    m_level = sum;
    m_pc    = (m_pc + 1) % (1 << SW);
    for (int v = 0; v < NV; v++) begin
      ap     = m_hf && (m_hv == v);
      st_cmd = ap && (m_hs == 0) && (m_hp != 0) && (m_ha != 0);
      if (st_cmd) begin
        m_ph[v] = 0; m_sq[v] = 0;
      end else if (m_st[v] != M_IDLE) begin
        m_ph[v]++;
        if (m_ph[v] == m_p[v]) begin
          m_ph[v] = 0; m_sq[v] = 1 - m_sq[v];
        end
      end
      if (st_cmd) begin
        m_st[v] = M_ATK; m_e[v] = 0; m_a[v] = m_ha; m_l[v] = m_hl; m_p[v] = m_hp;
      end else if (ap) begin
        if (m_st[v] == M_ATK || m_st[v] == M_SUS) m_st[v] = M_REL;
      end else if (strb) begin
        if (m_st[v] == M_ATK) begin
          m_e[v]++;
          if (m_e[v] == m_a[v]) m_st[v] = M_SUS;
        end else if (m_st[v] == M_SUS) begin
          if (m_l[v] == 0) m_st[v] = M_REL;
          else m_l[v]--;
        end else if (m_st[v] == M_REL) begin
          m_e[v] = (m_e[v] > 0) ? m_e[v] - 1 : 0;
          if (m_e[v] == 0) m_st[v] = M_IDLE;
        end
      end
      if (m_st[v] == M_IDLE) begin
        m_ph[v] = 0; m_sq[v] = 0;
      end
    end
    if (cmd_if.cmd_valid_i && !m_hf) begin
      m_hf = 1;
      m_hv = int'(cmd_if.cmd_voice_i);
      m_hs = int'(cmd_if.cmd_stop_i);
      m_hp = int'(cmd_if.cmd_period_i);
      m_ha = int'(cmd_if.cmd_amp_i);
      m_hl = int'(cmd_if.cmd_len_i);
    end else begin
      m_hf = 0;
    end
  endfunction

  task automatic check_all();
    int mb;
    mb = 0;
    for (int v = 0; v < NV; v++) if (m_st[v] != M_IDLE) mb |= (1 << v);
    chk("busy",  int'(busy), mb);
    chk("level", int'(level), m_level);
    chk("pwm",   int'(pwm), m_pwm);
    chk("ready", int'(cmd_if.cmd_ready_o), m_hf ? 0 : 1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic set_cmd(int voice, int stop, int period, int amp, int len);
    cmd_if.cmd_voice_i  = VW'(voice);
    cmd_if.cmd_stop_i   = stop[0];
    cmd_if.cmd_period_i = BW'(period);
    cmd_if.cmd_amp_i    = AMP_W'(amp);
    cmd_if.cmd_len_i    = LEN_W'(len);
  endtask

  // Issue one command and let it be applied (two edges).
  task automatic send(int voice, int stop, int period, int amp, int len);
    set_cmd(voice, stop, period, amp, len);
    cmd_if.cmd_valid_i = 1'b1;
    tick();
    cmd_if.cmd_valid_i = 1'b0;
    tick();
  endtask

  task automatic strobe();
    strb = 1'b1;
    tick();
    strb = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    int          voice;
    int          stop;
    int          period;
    int          amp;
    int          len;
    logic [3:0]  exp_busy;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int found, cnt;
    vecs[0] = '{0, 0, 3, 2, 1, 4'b0001};
    vecs[1] = '{2, 0, 5, 3, 2, 4'b0101};
    vecs[2] = '{1, 0, 0, 4, 1, 4'b0101};  // zero period acts as stop on idle voice
    vecs[3] = '{3, 0, 6, 0, 1, 4'b0101};  // zero amplitude acts as stop
    vecs[4] = '{3, 1, 6, 5, 1, 4'b0101};  // stop to idle voice
    vecs[5] = '{0, 0, 4, 5, 0, 4'b0101};  // retrigger of busy voice
    vecs[6] = '{3, 0, 2, 1, 0, 4'b1101};

    rst = 1'b1;
    strb = 1'b0;
    cmd_if.cmd_valid_i = 1'b0;
    set_cmd(0, 0, 0, 0, 0);
    model_reset();

    // Reset held with valid asserted: nothing accepted, outputs quiet.
    set_cmd(1, 0, 3, 7, 2);
    cmd_if.cmd_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_busy",  int'(busy), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_pwm",   int'(pwm), 0);
      chk("rst_ready", int'(cmd_if.cmd_ready_o), 1);
    end
    cmd_if.cmd_valid_i = 1'b0;
    rst = 1'b0;
    tick();
    chk("post_rst_ready", int'(cmd_if.cmd_ready_o), 1);
    chk("post_rst_busy",  int'(busy), 0);

    // Command table, no strobes.
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].voice, vecs[i].stop, vecs[i].period, vecs[i].amp, vecs[i].len);
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
    end
    strobe(); strobe(); strobe();
    chk("vec_strobes_busy", int'(busy), 4'b0101);

    // Single voice P=3 A=2 L=1, strobe every 10 cycles.
    do_reset();
    set_cmd(0, 0, 3, 2, 1);
    cmd_if.cmd_valid_i = 1'b1;
    tick();
    cmd_if.cmd_valid_i = 1'b0;
    chk("single_ready_low", int'(cmd_if.cmd_ready_o), 0);
    chk("single_busy_pre",  int'(busy[0]), 0);
    tick();
    chk("single_busy_rise", int'(busy[0]), 1);
    chk("single_ready_back", int'(cmd_if.cmd_ready_o), 1);
    for (int s = 1; s <= 6; s++) begin
      for (int i = 0; i < 9; i++) tick();
      strobe();
      if (s == 5) chk("single_busy_s5", int'(busy[0]), 1);
      if (s == 6) chk("single_busy_s6", int'(busy[0]), 0);
    end
    for (int i = 0; i < 4; i++) tick();

    // Backpressure: two consecutive valid cycles for different voices.
    do_reset();
    set_cmd(1, 0, 4, 3, 2);
    cmd_if.cmd_valid_i = 1'b1;
    tick();
    chk("bp_ready_low", int'(cmd_if.cmd_ready_o), 0);
    set_cmd(2, 0, 5, 3, 2);
    tick();
    chk("bp_ready_high", int'(cmd_if.cmd_ready_o), 1);
    chk("bp_busy_first", int'(busy), 4'b0010);
    tick();
    cmd_if.cmd_valid_i = 1'b0;
    chk("bp_ready_low2", int'(cmd_if.cmd_ready_o), 0);
    tick();
    chk("bp_busy_both", int'(busy), 4'b0110);

    // Stop mid-attack from E=5.
    do_reset();
    send(0, 0, 4, 15, 0);
    for (int s = 0; s < 5; s++) begin strobe(); tick(); end
    send(0, 1, 0, 0, 0);
    chk("stop_busy_rel", int'(busy[0]), 1);
    send(3, 1, 0, 0, 0);
    chk("stop_idle_stays", int'(busy[3]), 0);
    for (int s = 0; s < 4; s++) begin strobe(); tick(); end
    chk("stop_busy_4", int'(busy[0]), 1);
    strobe();
    chk("stop_busy_5", int'(busy[0]), 0);

    // Full mix with P=8: an all-high window gives level 60.
    do_reset();
    for (int v = 0; v < NV; v++) send(v, 0, 8, 15, 255);
    for (int s = 0; s < 15; s++) strobe();
    found = 0;
    for (int i = 0; i < 64 && found == 0; i++) begin
      tick();
      if (level == SW'(60)) found = 1;
    end
    chk("mix60_seen", found, 1);

    // Long period keeps all squares high: PWM duty is 60/64.
    do_reset();
    for (int v = 0; v < NV; v++) send(v, 0, 200, 15, 255);
    for (int s = 0; s < 15; s++) strobe();
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      tick();
      if (level == SW'(60)) found = 1;
    end
    chk("mix60_long_seen", found, 1);
    tick(); tick();
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (pwm) cnt++;
    end
    chk("pwm60of64", cnt, 60);
    for (int v = 0; v < NV; v++) send(v, 1, 0, 0, 0);
    for (int s = 0; s < 16; s++) strobe();
    tick(); tick(); tick();
    chk("mix_idle_busy",  int'(busy), 0);
    chk("mix_idle_level", int'(level), 0);
    chk("mix_idle_pwm",   int'(pwm), 0);

    // Start applied on a strobe edge: that voice ignores the strobe.
    do_reset();
    send(1, 0, 3, 1, 0);
    set_cmd(0, 0, 5, 1, 0);
    cmd_if.cmd_valid_i = 1'b1;
    tick();
    cmd_if.cmd_valid_i = 1'b0;
    strobe();
    chk("coll_busy0", int'(busy), 4'b0011);
    strobe();
    strobe();
    chk("coll_busy2", int'(busy), 4'b0001);
    strobe();
    chk("coll_busy3", int'(busy), 4'b0000);

    // Reset mid-note silences everything on the next edge.
    send(2, 0, 2, 9, 50);
    for (int s = 0; s < 9; s++) strobe();
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy",  int'(busy), 0);
    chk("midrst_level", int'(level), 0);
    chk("midrst_pwm",   int'(pwm), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cmd_if.cmd_valid_i = ($urandom_range(0, 2) == 0);
      set_cmd($urandom_range(0, NV - 1),
              ($urandom_range(0, 3) == 0) ? 1 : 0,
              $urandom_range(0, 12),
              $urandom_range(0, 15),
              $urandom_range(0, 5));
      strb = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 999) == 0);
      tick();
    end
    cmd_if.cmd_valid_i = 1'b0;
    strb = 1'b0;
    rst  = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
